// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32 load/store unit driving a word-wide data memory (RMW for SB/SH).
// Define LSU_MISALIGN_CHK_EN to report misaligned H/W accesses as errors instead of force-aligning.
module lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rword_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;

  logic                illegal_d;
  logic                misalign_d;
  logic                unused_addr;

  // Address bits above the memory size wrap, so they are deliberately dropped.
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign illegal_d = req_we ? (req_funct3 > 3'd2)
                            : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign_d = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd4:    load_ext = {24'h0, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd5:    load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    case (f3)
      3'd0:    m[{lane, 3'b000} +: 8] = wd[7:0];
      3'd1:    m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rword_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
            if (illegal_d || misalign_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we || (req_funct3 != 3'd2)) begin
              state_q <= RD;
            end else begin
              state_q <= WR;
            end
          end
        end
        RD: begin
          rword_q <= mem_rdata;
          if (we_q) begin
            state_q <= WR;
          end else begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_ext(mem_rdata, funct3_q, addr_q[1:0]);
          end
        end
        WR: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes are gated by reset directly so an aborted WR never writes.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign mem_read   = (state_q == RD) && !reset;
  assign mem_write  = (state_q == WR) && !reset;
  assign mem_addr   = reset ? '0 : addr_q[ADDR_W+1:2];
  assign mem_wdata  = mem_write ? store_merge(rword_q, wdata_q, funct3_q, addr_q[1:0]) : 32'h0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed bench for lsu_ctrl with a byte-addressed reference memory model.
module tb_lsu_ctrl;
  localparam int ADDR_W = 10;
  localparam int NW = 1 << ADDR_W;
  localparam int NB = 4 * NW;
`ifdef LSU_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0] mem_arr [0:NW-1];
  logic [7:0]  ref_b [0:NB-1];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = -1, exp_wr = -1, exp_resp = -1, busy_lo = -1;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0] exp_wword = 32'h0, exp_rdata = 32'h0;
  logic exp_err = 1'b0;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_write) mem_arr[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the windows the model predicted.
  always @(negedge clk) begin
    if (!reset) begin
      check("resp_valid", resp_valid, cyc == exp_resp);
      if (cyc == exp_resp) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", resp_err, exp_err);
      end
      check("mem_read", mem_read, cyc == exp_rd);
      check("mem_write", mem_write, cyc == exp_wr);
      if (cyc == exp_rd || cyc == exp_wr) check("mem_addr", mem_addr, exp_addr);
      if (cyc == exp_wr) check("mem_wdata", mem_wdata, exp_wword);
      check("req_ready", req_ready, !(cyc >= busy_lo && cyc <= exp_resp));
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    mem_arr[idx] = v;
    for (int i = 0; i < 4; i++) ref_b[4*idx+i] = v[8*i +: 8];
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic pin, input logic [31:0] pin_val);
    int a, base, a_al, lat, tries, acc;
    logic bad;
    logic [31:0] w, r;
    a = int'(addr & 32'(NB - 1));
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (CHK_EN && (f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) bad = 1'b1;
    if (CHK_EN && f3 == 3'd2 && (a % 4 != 0)) bad = 1'b1;
    base = a - a % 4;
    if (f3[1:0] == 2'd1) a_al = a - a % 2;
    else if (f3[1:0] == 2'd2) a_al = base;
    else a_al = a;
    w = 32'h0;
    r = 32'h0;
    if (!bad && we) begin
      for (int i = 0; i < (1 << f3[1:0]); i++) ref_b[a_al+i] = wd[8*i +: 8];
      w = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    end else if (!bad) begin
      case (f3)
        3'd0: r = {{24{ref_b[a][7]}}, ref_b[a]};
        3'd4: r = {24'h0, ref_b[a]};
        3'd1: r = {{16{ref_b[a_al+1][7]}}, ref_b[a_al+1], ref_b[a_al]};
        3'd5: r = {16'h0, ref_b[a_al+1], ref_b[a_al]};
        default: r = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
      endcase
    end
    if (pin) check("model_pin", we ? w : r, pin_val);

    tries = 0;
    while (!req_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    lat = bad ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
    busy_lo   = acc;
    exp_resp  = acc + lat - 1;
    exp_rd    = (!bad && (!we || f3 != 3'd2)) ? acc : -1;
    exp_wr    = (!bad && we) ? acc + lat - 2 : -1;
    exp_addr  = ADDR_W'(base / 4);
    exp_wword = w;
    exp_rdata = r;
    exp_err   = bad;
    while (cyc <= exp_resp) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) preload(i, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Load aborted by a two-cycle reset while in RD.
    preload(4, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_read", mem_read, 0);
    check("abort_req_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready_after", req_ready, 1);

    // SW then LW through the same word.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    check("sw_word_addr", exp_addr, 4);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);

    // SB into the top lane, then signed/unsigned byte reads.
    preload(4, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h13, 32'h00000080, 1'b1, 32'h80223344);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 1'b1, 32'h00000080);

    // SH into the upper half, then signed/unsigned half reads.
    preload(4, 32'h11223344);
    do_req(1'b1, 3'd1, 32'h12, 32'h0000A5A5, 1'b1, 32'hA5A53344);
    do_req(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 32'hFFFFA5A5);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, 1'b1, 32'h0000A5A5);

    // Illegal funct3 for load and store.
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0);
    do_req(1'b1, 3'd4, 32'h20, 32'h12345678, 1'b0, 32'h0);

    // Misaligned word and half; high address bits wrap.
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 1'b1, CHK_EN ? 32'h0 : 32'hA5A53344);
    do_req(1'b0, 3'd1, 32'h13, 32'h0, 1'b1, CHK_EN ? 32'h0 : 32'hFFFFA5A5);
    do_req(1'b0, 3'd2, 32'h00001010, 32'h0, 1'b1, 32'hA5A53344);

    // Low lanes of another word, including a positive byte and an unsigned half.
    preload(8, 32'hCAFEF00D);
    do_req(1'b1, 3'd0, 32'h20, 32'h0000007F, 1'b1, 32'hCAFEF07F);
    do_req(1'b0, 3'd0, 32'h20, 32'h0, 1'b1, 32'h0000007F);
    do_req(1'b1, 3'd1, 32'h22, 32'h00008001, 1'b1, 32'h8001F07F);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, 1'b1, 32'h00008001);
    do_req(1'b0, 3'd1, 32'h20, 32'h0, 1'b1, 32'hFFFFF07F);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
